// File: rtl/laplace_window_gen.sv
`timescale 1ns/1ps
// laplace_window_gen
// Streaming cross-window generator for the 4-neighbour Laplacian cores.
// Takes a raster-order pixel stream and keeps the two previous rows in line
// buffers. For every interior centre (r-1,c-1) it emits the cross window
// b (up), d (left), e (centre), f (right), h (down) through a registered output.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_pixel/in_valid     raster pixel stream input
//   in_ready              input accepted this cycle when in_valid is high
//   win_b..win_h          registered cross window around centre (r-1,c-1)
//   out_valid/out_ready   output handshake
//   out_last              marks the final window of a frame
//   frame_done            one-cycle pulse after the last pixel of a frame is accepted
module laplace_window_gen #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] win_b,
  output logic [DATA_W-1:0] win_d,
  output logic [DATA_W-1:0] win_e,
  output logic [DATA_W-1:0] win_f,
  output logic [DATA_W-1:0] win_h,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic {FILL, RUN} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;

  logic [DATA_W-1:0] lb_prev  [IMG_W];
  logic [DATA_W-1:0] lb_prev2 [IMG_W];
  logic [DATA_W-1:0] lb_rd_prev;
  logic [DATA_W-1:0] lb_rd_prev2;

  // Cross-window taps. Before the shift on accept of (r,c) they hold:
  // f_sr = p(r-1,c-1), e_sr = p(r-1,c-2), b_sr = p(r-2,c-1), h_sr = p(r,c-1).
  // The left tap d is therefore e_sr's pre-shift value, so no separate d stage
  // is kept.
  logic [DATA_W-1:0] f_sr;
  logic [DATA_W-1:0] e_sr;
  logic [DATA_W-1:0] b_sr;
  logic [DATA_W-1:0] h_sr;

  logic accept;
  logic last_col;
  logic last_pix;
  logic win_fire;

  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign last_col    = (col == COL_LAST);
  assign last_pix    = last_col && (row == ROW_LAST);
  // RUN is only entered once rows 0 and 1 are buffered, so it implies row >= 2.
  assign win_fire    = accept && (state == RUN) && (col >= COL_TWO);
  assign lb_rd_prev  = lb_prev[col];
  assign lb_rd_prev2 = lb_prev2[col];

  // Stage 0: raster position counters, fill/run control, frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      state      <= FILL;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_pix;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        case (state)
          FILL: if (last_col && (row == ROW_ONE)) state <= RUN;
          RUN:  if (last_pix) state <= FILL;
          default: state <= FILL;
        endcase
      end
    end
  end

  // Line buffers are overwritten by rows 0 and 1 of each frame before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_prev2[col] <= lb_prev[col];
      lb_prev[col]  <= in_pixel;
    end
  end

  // Stage 0: neighbourhood shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_sr <= '0;
      e_sr <= '0;
      b_sr <= '0;
      h_sr <= '0;
    end else if (accept) begin
      f_sr <= lb_rd_prev;
      e_sr <= f_sr;
      b_sr <= lb_rd_prev2;
      h_sr <= in_pixel;
    end
  end

  // Stage 1: output register, holds until drained; reloads with no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      win_b     <= '0;
      win_d     <= '0;
      win_e     <= '0;
      win_f     <= '0;
      win_h     <= '0;
    end else if (win_fire) begin
      out_valid <= 1'b1;
      out_last  <= last_pix;
      win_b     <= b_sr;
      win_d     <= e_sr;
      win_e     <= f_sr;
      win_f     <= lb_rd_prev;
      win_h     <= h_sr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
